hazard_sched_ctrl: RTL and testbench

//  Pipeline scheduler for the decode stage: tracks destination registers of
//  in-flight instructions (EX..WB), detects RAW hazards against the ID-stage

---
 rtl/hazard_pkg.sv | 47 ++++
 rtl/hazard_track_pipe.sv | 45 ++++
 rtl/hazard_sched_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_sched_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard scheduler.
// Used by hazard_track_pipe and hazard_sched_ctrl (optional macro: HAZARD_FWD_EN).
package hazard_pkg;

  // One in-flight instruction as seen from ID: valid, destination, RegWrite, MemRead.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } track_entry_t;

  // IF/ID flush sequencer states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

  // Operand source encodings driven on fwd_a / fwd_b.
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // XZR reads as zero and is never a real dependency.
  localparam logic [4:0] ZERO_REG_DEF = 5'd31;

  // True when entry e will write register src (XZR excluded).
  function automatic logic entry_match(input track_entry_t e,
                                       input logic [4:0]   src,
                                       input logic [4:0]   zero_reg);
    return e.v & e.wr & (e.rd == src) & (src != zero_reg);
  endfunction

  // Youngest producer wins: EX result before MEM result before register file.
  function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
    logic [1:0] sel;
    if (hit_ex) begin
      sel = FWD_EX;
    end else if (hit_mem) begin
      sel = FWD_MEM;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_track_pipe.sv
// Shift register of in-flight destination records (entry 0 = EX stage) with
// per-entry match flags against the two ID-stage source registers.
module hazard_track_pipe
  import hazard_pkg::*;
#(
  parameter int         DEPTH    = 3,
  parameter logic [4:0] ZERO_REG = ZERO_REG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  track_entry_t     load_entry,
  input  logic [4:0]       src_a,
  input  logic [4:0]       src_b,
  input  logic             src_b_used,
  output logic [DEPTH-1:0] match_a,
  output logic [DEPTH-1:0] match_b,
  output logic [DEPTH-1:0] ld_vec
);

  track_entry_t pipe [DEPTH];

  // Advance every cycle; the oldest entry simply falls off the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= load_entry;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Parallel compare of every tracked destination against both sources.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i] = entry_match(pipe[i], src_a, ZERO_REG);
      match_b[i] = src_b_used & entry_match(pipe[i], src_b, ZERO_REG);
      ld_vec[i]  = pipe[i].ld;
    end
  end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Decode-stage pipeline scheduler: RAW hazard stall/bubble generation,
// operand forwarding selects and post-branch IF/ID flush sequencing.
// Optional macro HAZARD_FWD_EN: forwarding present, only load-use stalls.
module hazard_sched_ctrl
  import hazard_pkg::*;
#(
  parameter int         PIPE_DEPTH   = 3,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [4:0] ZERO_REG     = ZERO_REG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_rm_used,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       ex_pcsrc,
  output logic       stall,
  output logic       bubble,
  output logic       flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Remaining flush cycles after the current one; reload leaves FSM idle when only one is needed.
  localparam logic [1:0]   CNT_LOAD     = 2'(FLUSH_CYCLES - 1);
  localparam flush_state_t RELOAD_STATE = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;

  flush_state_t    state;
  logic [1:0]      cnt;
  logic            flush_s;
  logic            stall_s;
  logic            hazard;
  logic [1:0]      fwd_a_s;
  logic [1:0]      fwd_b_s;
  track_entry_t    load_entry;
  logic [PIPE_DEPTH-1:0] match_a;
  logic [PIPE_DEPTH-1:0] match_b;
  logic [PIPE_DEPTH-1:0] ld_vec;
  logic [3:0]      ma_ext;
  logic [3:0]      mb_ext;
  logic            unused_track;

  hazard_track_pipe #(
    .DEPTH    (PIPE_DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_track (
    .clk        (clk),
    .rst        (rst),
    .load_entry (load_entry),
    .src_a      (id_rn),
    .src_b      (id_rm),
    .src_b_used (id_rm_used),
    .match_a    (match_a),
    .match_b    (match_b),
    .ld_vec     (ld_vec)
  );

  // Widen match vectors so stage 1 can be referenced for any depth.
  always_comb begin
    ma_ext = 4'(match_a);
    mb_ext = 4'(match_b);
  end

  // Entries beyond those needed for the selected hazard policy are intentionally ignored.
  assign unused_track = ^{ma_ext, mb_ext, ld_vec};

  // Flush FSM: flush is asserted in the branch cycle itself, then held by the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_pcsrc) begin
            state <= RELOAD_STATE;
            cnt   <= CNT_LOAD;
          end else begin
            state <= IDLE;
            cnt   <= 2'd0;
          end
        end
        FLUSH: begin
          if (ex_pcsrc) begin
            state <= RELOAD_STATE;
            cnt   <= CNT_LOAD;
          end else if (cnt <= 2'd1) begin
            state <= IDLE;
            cnt   <= 2'd0;
          end else begin
            state <= FLUSH;
            cnt   <= cnt - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Hazard detection and forwarding selection for the ID-stage operands.
  always_comb begin
`ifdef HAZARD_FWD_EN
    hazard  = ld_vec[0] & (match_a[0] | match_b[0]);
    fwd_a_s = fwd_select(ma_ext[0], ma_ext[1]);
    fwd_b_s = fwd_select(mb_ext[0], mb_ext[1]);
`else
    hazard  = |{match_a, match_b};
    fwd_a_s = FWD_REG;
    fwd_b_s = FWD_REG;
`endif
  end

  // Output gating: reset forces quiet outputs, flush overrides stall.
  always_comb begin
    if (rst) begin
      flush_s = 1'b0;
      stall_s = 1'b0;
      fwd_a   = FWD_REG;
      fwd_b   = FWD_REG;
    end else begin
      flush_s = ex_pcsrc | (state == FLUSH);
      stall_s = id_valid & hazard & ~flush_s;
      fwd_a   = fwd_a_s;
      fwd_b   = fwd_b_s;
    end
    stall  = stall_s;
    flush  = flush_s;
    bubble = stall_s | flush_s;
  end

  // Next EX-stage record: the ID instruction only if it actually advances.
  always_comb begin
    load_entry.v  = id_valid & ~stall_s & ~flush_s;
    load_entry.rd = id_rd;
    load_entry.wr = id_reg_write;
    load_entry.ld = id_mem_read;
  end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Self-checking bench for hazard_sched_ctrl; the reference model tracks issued
// instructions by issue cycle and derives hazards from their age.
module tb_hazard_sched_ctrl;

  localparam int         PIPE_DEPTH   = 3;
  localparam int         FLUSH_CYCLES = 2;
  localparam logic [4:0] ZR           = 5'd31;
`ifdef HAZARD_FWD_EN
  localparam int  T2_STALLS = 0;
  localparam int  T4_STALLS = 1;
  localparam int  T4_FWD    = 2;
`else
  localparam int  T2_STALLS = 3;
  localparam int  T4_STALLS = 3;
  localparam int  T4_FWD    = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rm_used, id_reg_write, id_mem_read, ex_pcsrc;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: what issued in which cycle.
  int   cyc       = 0;
  int   floor_cyc = 0;
  int   flush_end = -1;
  bit   iss [0:4095];
  logic [4:0] ird [0:4095];
  bit   iwr [0:4095];
  bit   ild [0:4095];

  // Last observed DUT outputs.
  logic o_stall, o_bubble, o_flush;
  logic [1:0] o_fa, o_fb;

  hazard_sched_ctrl #(
    .PIPE_DEPTH   (PIPE_DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .ZERO_REG     (ZR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rm_used   (id_rm_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .ex_pcsrc     (ex_pcsrc),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Instruction issued k cycles ago (since last reset) writes src?
  function automatic bit hit(input logic [4:0] src, input int k);
    int c;
    c = cyc - k;
    if (c < floor_cyc || c < 0) return 1'b0;
    return iss[c] && iwr[c] && (ird[c] == src) && (src != ZR);
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic used, input logic [4:0] rd, input logic rw,
                        input logic mr);
    id_valid = v; id_rn = rn; id_rm = rm; id_rm_used = used;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic tick(input string tag);
    logic e_stall, e_flush, e_bub, hz, ha, hb;
    logic [1:0] e_fa, e_fb;
    @(negedge clk);
    e_flush = !rst && (ex_pcsrc || (cyc <= flush_end));
    hz = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      ha = hit(id_rn, k);
      hb = id_rm_used && hit(id_rm, k);
`ifdef HAZARD_FWD_EN
      if (k == 1 && (ha || hb) && ild[cyc-1]) hz = 1'b1;
`else
      if (ha || hb) hz = 1'b1;
`endif
    end
`ifdef HAZARD_FWD_EN
    e_fa = hit(id_rn, 1) ? 2'd1 : ((PIPE_DEPTH > 1 && hit(id_rn, 2)) ? 2'd2 : 2'd0);
    e_fb = (id_rm_used && hit(id_rm, 1)) ? 2'd1 :
           ((PIPE_DEPTH > 1 && id_rm_used && hit(id_rm, 2)) ? 2'd2 : 2'd0);
`else
    e_fa = 2'd0;
    e_fb = 2'd0;
`endif
    if (rst) begin
      e_fa = 2'd0;
      e_fb = 2'd0;
    end
    e_stall = !rst && id_valid && hz && !e_flush;
    e_bub   = e_stall || e_flush;
    o_stall = stall; o_bubble = bubble; o_flush = flush; o_fa = fwd_a; o_fb = fwd_b;
    chk({tag, "/stall"},  32'(stall),  32'(e_stall));
    chk({tag, "/bubble"}, 32'(bubble), 32'(e_bub));
    chk({tag, "/flush"},  32'(flush),  32'(e_flush));
    chk({tag, "/fwd_a"},  32'(fwd_a),  32'(e_fa));
    chk({tag, "/fwd_b"},  32'(fwd_b),  32'(e_fb));
    @(posedge clk);
    #1;
    iss[cyc] = !rst && id_valid && !e_stall && !e_flush;
    ird[cyc] = id_rd;
    iwr[cyc] = id_reg_write;
    ild[cyc] = id_mem_read;
    if (rst) begin
      floor_cyc = cyc + 1;
      flush_end = -1;
    end else if (ex_pcsrc) begin
      flush_end = cyc + FLUSH_CYCLES - 1;
    end
    cyc++;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_pcsrc = 1'b0;
    repeat (PIPE_DEPTH + 1) tick("drain");
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 6);
    return (r == 6) ? ZR : 5'(r + 1);
  endfunction

  initial begin
    int n, nb;
    rst = 1'b1;
    ex_pcsrc = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick("reset");
    chk("reset_stall", 32'(o_stall), 32'd0);
    rst = 1'b0;
    tick("post_reset");

    // 1: reset arriving in the middle of a stall
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick("t1_prod");
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    tick("t1_cons");
    rst = 1'b1;
    tick("t1_rst");
    chk("t1_stall_in_rst", 32'(o_stall), 32'd0);
    rst = 1'b0;
    tick("t1_after");
    chk("t1_stall_after", 32'(o_stall), 32'd0);
    drain();

    // 2/3: ADD X5 then SUB X6,X5,X1, followed by another X5 consumer
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick("t2_add");
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    n = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      tick("t2_sub");
      if (o_bubble === 1'b1) nb++;
      if (o_stall !== 1'b1) break;
      n++;
    end
    chk("t2_stall_cycles", 32'(n), 32'(T2_STALLS));
    chk("t2_bubble_cycles", 32'(nb), 32'(T2_STALLS));
`ifdef HAZARD_FWD_EN
    chk("t3_fwd_a_ex", 32'(o_fa), 32'd1);
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
    tick("t3_next");
    chk("t3_fwd_a_mem", 32'(o_fa), 32'd2);
`endif
    drain();

    // 4: LDUR X7 then ADD X8,X7,X7
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick("t4_ld");
    set_id(1'b1, 5'd7, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick("t4_use");
      if (o_stall !== 1'b1) break;
      n++;
    end
    chk("t4_stall_cycles", 32'(n), 32'(T4_STALLS));
    chk("t4_fwd_a", 32'(o_fa), 32'(T4_FWD));
    chk("t4_fwd_b", 32'(o_fb), 32'(T4_FWD));
    drain();

    // 5: XZR producer never creates a dependency
    set_id(1'b1, 5'd1, 5'd2, 1'b1, ZR, 1'b1, 1'b0);
    tick("t5_prod");
    set_id(1'b1, ZR, ZR, 1'b1, 5'd3, 1'b1, 1'b0);
    tick("t5_cons");
    chk("t5_stall", 32'(o_stall), 32'd0);
    chk("t5_fwd_a", 32'(o_fa), 32'd0);
    chk("t5_fwd_b", 32'(o_fb), 32'd0);
    drain();

    // 6: taken branch in the same cycle as a pending stall
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick("t6_prod");
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);
    ex_pcsrc = 1'b1;
    tick("t6_c1");
    chk("t6_c1_flush", 32'(o_flush), 32'd1);
    chk("t6_c1_stall", 32'(o_stall), 32'd0);
    chk("t6_c1_bubble", 32'(o_bubble), 32'd1);
    ex_pcsrc = 1'b0;
    tick("t6_c2");
    chk("t6_c2_flush", 32'(o_flush), 32'd1);
    tick("t6_c3");
    chk("t6_c3_flush", 32'(o_flush), 32'd0);
    drain();

    // Randomized traffic against the reference model
    for (int i = 0; i < 500; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), pick_reg(), pick_reg(),
             1'($urandom_range(0, 1)), pick_reg(),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      ex_pcsrc = 1'($urandom_range(0, 9) == 0);
      rst = 1'($urandom_range(0, 149) == 0);
      tick("rand");
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
